// File: rtl/rmii_tx_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rmii_tx_arb_pkg                                            |
// | Description : Shared types and constants for the RMII transmit arbiter:  |
// |               FSM state enum, requester index type, byte counter width.  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package rmii_tx_arb_pkg;

   // Arbiter states; DRAIN is only reachable when length limiting is built in
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      DRAIN = 2'd2
   } arb_state_e;

   // Index of a requester port (0 or 1)
   typedef logic port_idx_t;

   // Width of the per-frame byte counter
   localparam int CNT_W = 11;

   // One-hot grant vector for a requester index
   function automatic logic [1:0] port_onehot(input port_idx_t p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axis_skid_buffer                                           |
// | Description : Two-entry AXI-Stream skid register for 8-bit data plus     |
// |               tlast. Registered output, one cycle of latency, full       |
// |               throughput; s_tready is the buffer-not-full indication.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module axis_skid_buffer (
   input  logic       clock,
   input  logic       aresetn,
   input  logic [7:0] s_tdata,
   input  logic       s_tlast,
   input  logic       s_tvalid,
   output logic       s_tready,
   output logic [7:0] m_tdata,
   output logic       m_tlast,
   output logic       m_tvalid,
   input  logic       m_tready
);

   logic [8:0] out_q,  out_d;
   logic [8:0] skid_q, skid_d;
   logic       out_vld_q,  out_vld_d;
   logic       skid_vld_q, skid_vld_d;
   logic       push;

   // Input may only be taken while the spill slot is free
   assign s_tready = ~skid_vld_q;
   assign push     = s_tvalid & ~skid_vld_q;

   // Refill the output slot from the skid slot first, then from the input;
   // when the output is held by a stalled consumer, park the input beat.
   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (!out_vld_q || m_tready) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else if (push) begin
            out_d     = {s_tlast, s_tdata};
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (push) begin
         skid_d     = {s_tlast, s_tdata};
         skid_vld_d = 1'b1;
      end
   end

   // Buffer storage with asynchronous clear
   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   assign m_tdata  = out_q[7:0];
   assign m_tlast  = out_q[8];
   assign m_tvalid = out_vld_q;

endmodule

`default_nettype wire

// File: rtl/rmii_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rmii_tx_arbiter                                            |
// | Description : Frame-atomic round-robin arbiter merging two AXI-Stream    |
// |               byte streams towards the RMII transmit serializer.         |
// |               Optional length limiting: RMII_TX_ARB_LEN_LIMIT_EN         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module rmii_tx_arbiter
   import rmii_tx_arb_pkg::*;
#(
   parameter int MAX_FRAME_BYTES = 1526
) (
   input  logic       clock,
   input  logic       aresetn,
   input  logic [7:0] saxis0_tdata,
   input  logic       saxis0_tvalid,
   output logic       saxis0_tready,
   input  logic       saxis0_tlast,
   input  logic [7:0] saxis1_tdata,
   input  logic       saxis1_tvalid,
   output logic       saxis1_tready,
   input  logic       saxis1_tlast,
   output logic [7:0] maxis_tdata,
   output logic       maxis_tvalid,
   input  logic       maxis_tready,
   output logic       maxis_tlast,
   output logic [1:0] grant,
   output logic       truncated
);

   arb_state_e state_q, state_d;
   port_idx_t  prio_q,  prio_d;
   port_idx_t  owner_q, owner_d;
   logic [1:0] grant_q, grant_d;

   logic       sel_valid, sel_last, sel_ready;
   logic [7:0] sel_data;
   logic       buf_valid, buf_last, buf_ready;
   logic       frame_end;

`ifdef RMII_TX_ARB_LEN_LIMIT_EN
   // Counter value while the last permitted beat is being accepted
   localparam logic [CNT_W-1:0] LAST_BEAT_CNT = CNT_W'(MAX_FRAME_BYTES - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             trunc_q, trunc_d;
`endif

   // Route the owner's stream onto the shared path
   assign sel_valid = owner_q ? saxis1_tvalid : saxis0_tvalid;
   assign sel_last  = owner_q ? saxis1_tlast  : saxis0_tlast;
   assign sel_data  = owner_q ? saxis1_tdata  : saxis0_tdata;

   // Next-state, grant, round-robin pointer and handshake steering
   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      owner_d   = owner_q;
      grant_d   = grant_q;
      sel_ready = 1'b0;
      buf_valid = 1'b0;
      buf_last  = sel_last;
      frame_end = 1'b0;
`ifdef RMII_TX_ARB_LEN_LIMIT_EN
      cnt_d     = cnt_q;
      trunc_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
`ifdef RMII_TX_ARB_LEN_LIMIT_EN
            cnt_d = '0;
`endif
            if (saxis0_tvalid || saxis1_tvalid) begin
               // Preferred port wins unless it has nothing to send
               owner_d = (prio_q ? saxis1_tvalid : saxis0_tvalid) ? prio_q : ~prio_q;
               grant_d = port_onehot(owner_d);
               state_d = PASS;
            end
         end
         PASS: begin
            sel_ready = buf_ready;
            buf_valid = sel_valid;
            if (sel_valid && buf_ready) begin
               if (sel_last) begin
                  frame_end = 1'b1;
               end
`ifdef RMII_TX_ARB_LEN_LIMIT_EN
               cnt_d = cnt_q + CNT_W'(1);
               if (!sel_last && (cnt_q == LAST_BEAT_CNT)) begin
                  // Cut the frame here: close it downstream, swallow the rest
                  buf_last = 1'b1;
                  trunc_d  = 1'b1;
                  state_d  = DRAIN;
               end
`endif
            end
         end
`ifdef RMII_TX_ARB_LEN_LIMIT_EN
         DRAIN: begin
            sel_ready = 1'b1;
            if (sel_valid && sel_last) begin
               frame_end = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      if (frame_end) begin
         state_d = IDLE;
         prio_d  = ~owner_q;
         grant_d = 2'b00;
      end
   end

   // Arbiter state registers
   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         grant_q <= 2'b00;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
      end
   end

`ifdef RMII_TX_ARB_LEN_LIMIT_EN
   // Byte counter and single-cycle truncation flag
   always_ff @(posedge clock or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q   <= '0;
         trunc_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
      end
   end
   assign truncated = trunc_q;
`else
   assign truncated = 1'b0;
`endif

   assign saxis0_tready = sel_ready & ~owner_q;
   assign saxis1_tready = sel_ready &  owner_q;
   assign grant         = grant_q;

   axis_skid_buffer u_out_buf (
      .clock    (clock),
      .aresetn  (aresetn),
      .s_tdata  (sel_data),
      .s_tlast  (buf_last),
      .s_tvalid (buf_valid),
      .s_tready (buf_ready),
      .m_tdata  (maxis_tdata),
      .m_tlast  (maxis_tlast),
      .m_tvalid (maxis_tvalid),
      .m_tready (maxis_tready)
   );

endmodule

`default_nettype wire

// File: tb/tb_rmii_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rmii_tx_arbiter                                         |
// | Description : Self-checking bench for rmii_tx_arbiter. A frame-level     |
// |               model predicts the output byte stream and truncations.     |
// |               Honours RMII_TX_ARB_LEN_LIMIT_EN (limit set to 8 bytes).   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_rmii_tx_arbiter;

`ifdef RMII_TX_ARB_LEN_LIMIT_EN
   localparam int MAXB     = 8;
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam int MAXB     = 1526;
   localparam bit LIMIT_EN = 1'b0;
`endif

   typedef logic [7:0] frame_t [$];

   logic       clock = 1'b0;
   logic       aresetn;
   logic [7:0] saxis0_tdata, saxis1_tdata, maxis_tdata;
   logic       saxis0_tvalid, saxis0_tready, saxis0_tlast;
   logic       saxis1_tvalid, saxis1_tready, saxis1_tlast;
   logic       maxis_tvalid, maxis_tready, maxis_tlast;
   logic [1:0] grant;
   logic       truncated;

   int checks   = 0;
   int failures = 0;

   logic [8:0] obs_q[$];
   int         obs_cyc[$];
   logic [8:0] exp_q[$];
   int         exp_trunc = 0;
   int         trunc_cnt = 0;
   int         cyc = 0;
   int         rdy_mode = 0;
   int         m_prio = 0;
   frame_t     f0a, f0b, f1a;

   logic       prev_stall = 1'b0;
   logic [8:0] prev_beat  = '0;
   logic [1:0] prev_grant = 2'b00;

   always #5 clock = ~clock;

   rmii_tx_arbiter #(.MAX_FRAME_BYTES(MAXB)) dut (
      .clock         (clock),
      .aresetn       (aresetn),
      .saxis0_tdata  (saxis0_tdata),
      .saxis0_tvalid (saxis0_tvalid),
      .saxis0_tready (saxis0_tready),
      .saxis0_tlast  (saxis0_tlast),
      .saxis1_tdata  (saxis1_tdata),
      .saxis1_tvalid (saxis1_tvalid),
      .saxis1_tready (saxis1_tready),
      .saxis1_tlast  (saxis1_tlast),
      .maxis_tdata   (maxis_tdata),
      .maxis_tvalid  (maxis_tvalid),
      .maxis_tready  (maxis_tready),
      .maxis_tlast   (maxis_tlast),
      .grant         (grant),
      .truncated     (truncated)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Output monitor: collects beats, checks stall stability, grant gaps, pulses
   always @(negedge clock) begin
      if (aresetn) begin
         if (prev_stall) begin
            chk("stall_valid", {31'd0, maxis_tvalid}, 32'd1);
            chk("stall_data", {23'd0, maxis_tlast, maxis_tdata}, {23'd0, prev_beat});
         end
         if (maxis_tvalid && maxis_tready) begin
            obs_q.push_back({maxis_tlast, maxis_tdata});
            obs_cyc.push_back(cyc);
         end
         if (grant !== prev_grant && grant !== 2'b00) begin
            chk("grant_idle_gap", {30'd0, prev_grant}, 32'd0);
            chk("grant_onehot", {31'd0, (grant == 2'b01 || grant == 2'b10)}, 32'd1);
         end
         if (truncated) trunc_cnt++;
         prev_stall = maxis_tvalid && !maxis_tready;
         prev_beat  = {maxis_tlast, maxis_tdata};
         prev_grant = grant;
      end else begin
         prev_stall = 1'b0;
         prev_grant = 2'b00;
      end
   end

   // Downstream ready: always, fixed 1,0,0,1 pattern, or random
   initial begin
      int ph;
      ph = 0;
      maxis_tready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         case (rdy_mode)
            0:       maxis_tready = 1'b1;
            1:       begin maxis_tready = ((ph % 4) == 0) || ((ph % 4) == 3); ph++; end
            default: maxis_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic drive(input int p, input logic [7:0] d, input logic l, input logic v);
      if (p == 0) begin
         saxis0_tdata = d; saxis0_tlast = l; saxis0_tvalid = v;
      end else begin
         saxis1_tdata = d; saxis1_tlast = l; saxis1_tvalid = v;
      end
   endtask

   task automatic make_frame(output frame_t f, input int len);
      f.delete();
      for (int i = 0; i < len; i++) f.push_back(8'($urandom));
   endtask

   // Present a frame beat by beat; optional mid-frame valid gap; stop_at >= 0
   // leaves that beat presented and returns without waiting for it.
   task automatic send_frame(input int p, input frame_t f, input int gap_at,
                             input int gap_len, input int stop_at);
      for (int i = 0; i < f.size(); i++) begin
         bit done;
         int guard;
         if (i == gap_at && i > 0 && gap_len > 0) begin
            drive(p, 8'h00, 1'b0, 1'b0);
            repeat (gap_len) @(posedge clock);
            #1;
         end
         drive(p, f[i], (i == f.size() - 1), 1'b1);
         if (i == stop_at) return;
         done  = 1'b0;
         guard = 0;
         while (!done && guard < 2000) begin
            @(negedge clock);
            if ((p == 0) ? saxis0_tready : saxis1_tready) begin
               done = 1'b1;
               chk("grant_owner", {30'd0, grant}, (p == 0) ? 32'd1 : 32'd2);
            end
            @(posedge clock);
            #1;
            guard++;
         end
         chk("handshake", {31'd0, done}, 32'd1);
      end
      drive(p, 8'h00, 1'b0, 1'b0);
   endtask

   // Reference: expected output of one frame, cut at MAXB when limiting
   task automatic add_frame(input frame_t f);
      int n, keep;
      bit cut;
      n    = f.size();
      cut  = LIMIT_EN && (n > MAXB);
      keep = cut ? MAXB : n;
      for (int i = 0; i < keep; i++) exp_q.push_back({(i == keep - 1), f[i]});
      if (cut) exp_trunc++;
   endtask

   // Reference: frame-level round robin over the pending frames of each port
   task automatic model_run(input int n0, input int n1);
      int i0, i1, w;
      bit v0, v1;
      i0 = 0; i1 = 0;
      while (i0 < n0 || i1 < n1) begin
         v0 = (i0 < n0);
         v1 = (i1 < n1);
         w  = ((m_prio == 1) ? v1 : v0) ? m_prio : 1 - m_prio;
         if (w == 0) begin
            add_frame((i0 == 0) ? f0a : f0b);
            i0++;
         end else begin
            add_frame(f1a);
            i1++;
         end
         m_prio = 1 - w;
      end
   endtask

   task automatic drain_and_compare(input bit consec);
      int guard;
      guard = 0;
      while (obs_q.size() < exp_q.size() && guard < 2000) begin
         @(negedge clock);
         guard++;
      end
      repeat (4) @(negedge clock);
      chk("beat_count", obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk("beat", {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
      chk("trunc_pulses", trunc_cnt, exp_trunc);
      if (consec && obs_q.size() > 0)
         chk("consecutive", obs_cyc[obs_cyc.size() - 1] - obs_cyc[0], obs_q.size() - 1);
      obs_q.delete();
      obs_cyc.delete();
      exp_q.delete();
      exp_trunc = 0;
      trunc_cnt = 0;
      @(posedge clock);
      #1;
   endtask

   task automatic run_scen(input int n0, input int n1, input int g0_at, input int g0_len,
                           input int g1_at, input int g1_len, input bit consec);
      model_run(n0, n1);
      fork
         begin
            if (n0 > 0) send_frame(0, f0a, g0_at, g0_len, -1);
            if (n0 > 1) send_frame(0, f0b, 0, 0, -1);
         end
         begin
            if (n1 > 0) send_frame(1, f1a, g1_at, g1_len, -1);
         end
      join
      drain_and_compare(consec);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tvalid"}, {31'd0, maxis_tvalid}, 32'd0);
      chk({tag, "_tdata"},  {24'd0, maxis_tdata},  32'd0);
      chk({tag, "_tlast"},  {31'd0, maxis_tlast},  32'd0);
      chk({tag, "_grant"},  {30'd0, grant},        32'd0);
      chk({tag, "_trunc"},  {31'd0, truncated},    32'd0);
      chk({tag, "_tready0"}, {31'd0, saxis0_tready}, 32'd0);
      chk({tag, "_tready1"}, {31'd0, saxis1_tready}, 32'd0);
   endtask

   initial begin
      int n0, n1, l0, l1, ga, gl;
      aresetn = 1'b0;
      drive(0, 8'h00, 1'b0, 1'b0);
      drive(1, 8'h00, 1'b0, 1'b0);
      #1;
      check_reset_outputs("por");
      repeat (3) @(posedge clock);
      @(negedge clock);
      aresetn = 1'b1;
      @(posedge clock);
      #1;

      // Contention: port 0 first, then port 1 ahead of port 0's next frame
      make_frame(f0a, 4); make_frame(f0b, 4); make_frame(f1a, 4);
      run_scen(2, 1, 0, 0, 0, 0, 1'b0);

      // Single known frame, back-to-back output
      f0a = '{8'h55, 8'h55, 8'hD5, 8'hAB, 8'hCD};
      run_scen(1, 0, 0, 0, 0, 0, 1'b1);

      // Downstream stalls with 1,0,0,1 ready pattern
      rdy_mode = 1;
      make_frame(f1a, 8);
      run_scen(0, 1, 0, 0, 0, 0, 1'b0);
      rdy_mode = 0;

      // Owner's tvalid gap of 5 cycles while port 1 waits
      make_frame(f0a, 8); make_frame(f1a, 5);
      run_scen(1, 1, 3, 5, 0, 0, 1'b0);

      // Single-byte frame
      make_frame(f0a, 1);
      run_scen(1, 0, 0, 0, 0, 0, 1'b0);

      // Randomized traffic with random stalls and gaps
      rdy_mode = 2;
      for (int it = 0; it < 12; it++) begin
         n0 = $urandom_range(0, 2);
         n1 = (n0 == 0) ? 1 : $urandom_range(0, 1);
         l0 = $urandom_range(2, 12);
         l1 = $urandom_range(2, 12);
         make_frame(f0a, l0);
         make_frame(f0b, $urandom_range(2, 12));
         make_frame(f1a, l1);
         ga = $urandom_range(1, l0 - 1);
         gl = $urandom_range(0, 5);
         run_scen(n0, n1, ga, gl, $urandom_range(1, l1 - 1), $urandom_range(0, 5), 1'b0);
      end
      rdy_mode = 0;

      // Reset while byte 3 of a 6-byte frame is presented
      make_frame(f0a, 6);
      send_frame(0, f0a, 0, 0, 2);
      #2 aresetn = 1'b0;
      #1 check_reset_outputs("mid_reset");
      drive(0, 8'h00, 1'b0, 1'b0);
      obs_q.delete(); obs_cyc.delete(); exp_q.delete();
      exp_trunc = 0; trunc_cnt = 0; m_prio = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      aresetn = 1'b1;
      obs_q.delete(); obs_cyc.delete();
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("grant_after_reset", {30'd0, grant}, 32'd0);
         chk("tvalid_after_reset", {31'd0, maxis_tvalid}, 32'd0);
      end
      @(posedge clock);
      #1;
      run_scen(1, 0, 0, 0, 0, 0, 1'b0);

`ifdef RMII_TX_ARB_LEN_LIMIT_EN
      // Length limit: 12 bytes cut to 8, exactly 8 passes, 9 cut with stalls
      make_frame(f0a, 12);
      run_scen(1, 0, 0, 0, 0, 0, 1'b0);
      make_frame(f1a, 8);
      run_scen(0, 1, 0, 0, 0, 0, 1'b0);
      rdy_mode = 2;
      make_frame(f0a, 9); make_frame(f1a, 10);
      run_scen(1, 1, 0, 0, 0, 0, 1'b0);
      rdy_mode = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rmii_tx_arbiter.md
RMII_TX_ARBITER -- requirements
Module: rmii_tx_arbiter

Interface
REQ-001 Parameter MAX_FRAME_BYTES, default 1526, sets the byte limit per granted frame, counting preamble and SFD bytes.
REQ-002 Port clock, input, 1, the single clock; all logic is rising-edge.
REQ-003 Port aresetn, input, 1, asynchronous active-low reset.
REQ-004 Ports saxis0_tdata/tvalid/tready/tlast, input/input/output/input, 8/1/1/1: AXI-Stream requester 0 (frames including preamble and SFD).
REQ-005 Ports saxis1_tdata/tvalid/tready/tlast, input/input/output/input, 8/1/1/1: AXI-Stream requester 1.
REQ-006 Ports maxis_tdata/tvalid/tready/tlast, output/output/input/output, 8/1/1/1: stream to the RMII transmit serializer.
REQ-007 Port grant, output, 2, one-hot owner of the current frame; 2'b00 when idle.
REQ-008 Port truncated, output, 1, single-cycle pulse when a frame is cut at MAX_FRAME_BYTES.

Function
REQ-009 Arbitration is frame-atomic: once granted, a requester owns the output until its tlast beat is accepted.
REQ-010 FSM states: IDLE, PASS, DRAIN; the reset state is IDLE.
REQ-011 IDLE: both saxis*_tready = 0; when any tvalid = 1, select the winner, set grant, and move to PASS on the next edge.
REQ-012 Round-robin: the prio pointer names the preferred port; the other port wins only if the preferred port's tvalid = 0; prio resets to 0.
REQ-013 On the accepted tlast beat, prio becomes the non-winning port; the next edge enters IDLE, which lasts at least one cycle between frames.
REQ-014 PASS: the granted saxis_tready equals the buffer-not-full signal, and data/tlast go to the output buffer; the non-granted tready = 0.
REQ-015 Output buffer: 2-entry skid register; latency from input acceptance to maxis_tvalid is 1 cycle; it sustains 1 beat/cycle when maxis_tready = 1.
REQ-016 maxis_tvalid never drops and maxis_tdata never changes while maxis_tvalid = 1 and maxis_tready = 0.
REQ-017 The 11-bit byte counter clears in IDLE and increments on each accepted beat in PASS.
REQ-018 A requester dropping tvalid mid-frame stalls PASS indefinitely; there is no timeout.
REQ-019 grant stays valid through PASS and DRAIN, and clears on entry to IDLE.

Reset
REQ-020 aresetn low asynchronously forces: state IDLE, prio 0, counter 0, buffer empty, maxis_tvalid 0, maxis_tdata 0, maxis_tlast 0, grant 0, truncated 0, all saxis*_tready 0.
REQ-021 A reset mid-frame discards buffered beats; after release the aborted requester re-arbitrates from IDLE and no partial-frame continuation is emitted.
REQ-022 Reset release is synchronous to clock.

Configuration
REQ-023 Macro RMII_TX_ARB_LEN_LIMIT_EN selects length limiting.
REQ-024 Defined: when the accepted beat is number MAX_FRAME_BYTES without tlast, it is forwarded with maxis_tlast forced to 1, truncated pulses, and the FSM enters DRAIN.
REQ-025 Defined, DRAIN: the granted tready = 1, beats are discarded and not forwarded, and the accepted tlast moves the FSM to IDLE with the prio update.
REQ-026 Not defined: no counter, no DRAIN state, and truncated is tied to 0.

Structure
REQ-027 Package rmii_tx_arb_pkg holds the state enum (IDLE, PASS, DRAIN), the port index type, and the counter width constant.
REQ-028 Sub-module axis_skid_buffer, 8-bit data plus tlast, implements the output buffer.

Verification
REQ-029 Single port 0 frame 55 55 D5 AB CD(last), maxis_tready = 1 -> maxis shows the same 5 bytes on consecutive cycles, tlast on CD, grant = 01 during the frame.
REQ-030 Both ports valid at once, frames of 4 bytes each -> port 0 goes first, then at least 1 idle cycle, then port 1; next simultaneous contention serves port 1 first.
REQ-031 Port 1 frame with maxis_tready toggling 1,0,0,1 -> no lost or duplicated bytes, and maxis_tdata is stable during stall cycles.
REQ-032 Reset pulse during byte 3 of a 6-byte frame -> outputs reach the REQ-020 values immediately, and after release grant = 00 until tvalid is re-presented.
REQ-033 RMII_TX_ARB_LEN_LIMIT_EN defined, MAX_FRAME_BYTES = 8, 12-byte frame -> 8 bytes output with tlast on byte 8, one truncated pulse, 4 bytes drained, then IDLE.
REQ-034 Port 0 tvalid gap of 5 cycles mid-frame while port 1 is valid -> grant stays 01, and port 1 starts only after port 0's tlast.
